// File: rtl/bp_me_cfg_seq_loader.sv
// Configuration sequence loader: walks a table of num_entries_p (addr, data)
// pairs and issues each as an 8-byte write command. The number of writes
// awaiting acknowledgement is bounded by credits_p. The loader waits for all
// acks, then pulses done_o and reports stray acks on the sticky err_o.
module bp_me_cfg_seq_loader #(
  parameter int addr_width_p  = 40,
  parameter int data_width_p  = 64,
  parameter int num_entries_p = 16,
  parameter int credits_p     = 4,
  localparam int idx_w_lp     = (num_entries_p > 1) ? $clog2(num_entries_p) : 1,
  localparam int cnt_w_lp     = $clog2(credits_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  output logic [idx_w_lp-1:0]     entry_idx_o,
  input  logic [addr_width_p-1:0] entry_addr_i,
  input  logic [data_width_p-1:0] entry_data_i,
  output logic                    fwd_v_o,
  input  logic                    fwd_ready_and_i,
  output logic [addr_width_p-1:0] fwd_addr_o,
  output logic [data_width_p-1:0] fwd_data_o,
  input  logic                    rev_v_i,
  output logic                    rev_ready_and_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_SEND,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_entries_p - 1);
  localparam logic [cnt_w_lp-1:0] credits_lp  = cnt_w_lp'(credits_p);

  state_e              state_q, state_d;
  logic [idx_w_lp-1:0] idx_q, idx_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                fwd_v_q, fwd_v_d;
  logic                rev_rdy_q, rev_rdy_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fwd_acc, rev_acc;

  assign fwd_acc = fwd_v_q & fwd_ready_and_i;
  assign rev_acc = rev_v_i & rev_rdy_q;

  // Next-state logic: sequencing, credit accounting and stray-ack detection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SEND;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_SEND, S_DRAIN: begin
        // A simultaneous accept and ack cancel out
        if (fwd_acc && !rev_acc) begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end else if (!fwd_acc && rev_acc) begin
          if (cnt_q == '0) err_d = 1'b1;
          else             cnt_d = cnt_q - cnt_w_lp'(1);
        end
        // idx parks on the last entry instead of wrapping
        if (state_q == S_SEND && fwd_acc) begin
          if (idx_q == last_idx_lp) state_d = S_DRAIN;
          else                      idx_d   = idx_q + idx_w_lp'(1);
        end
        if (state_q == S_DRAIN && cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from next state so every status flag leaves a register
  always_comb begin
    fwd_v_d   = (state_d == S_SEND) && (cnt_d < credits_lp);
    rev_rdy_d = (state_d == S_SEND) || (state_d == S_DRAIN);
    busy_d    = rev_rdy_d;
    done_d    = (state_d == S_DONE);
  end

  // State and registered outputs; reset abandons any in-flight writes
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_RESET;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      fwd_v_q   <= 1'b0;
      rev_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fwd_v_q   <= fwd_v_d;
      rev_rdy_q <= rev_rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign entry_idx_o     = idx_q;
  assign fwd_v_o         = fwd_v_q;
  assign fwd_addr_o      = fwd_v_q ? entry_addr_i : '0;
  assign fwd_data_o      = fwd_v_q ? entry_data_i : '0;
  assign rev_ready_and_o = rev_rdy_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_bp_me_cfg_seq_loader.sv
// Directed bench for bp_me_cfg_seq_loader: instance A (4 entries, 3 credits)
// and instance B (4 entries, 2 credits) share clock and reset.
module tb_bp_me_cfg_seq_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [39:0] ta(input int i);
    return 40'hA0_0000_0000 + 40'(i) * 40'h100;
  endfunction
  function automatic logic [63:0] td(input int i);
    return 64'hC0FF_EE00_0000_0000 | 64'(i * 7 + 1);
  endfunction

  // ---------------- instance A ----------------
  logic        start_a = 1'b0, ready_a = 1'b0, man_rev_a = 1'b0, auto_a = 1'b0;
  logic [1:0]  idx_a;
  logic [39:0] eaddr_a, faddr_a;
  logic [63:0] edata_a, fdata_a;
  logic        fwd_v_a, rev_a, rev_rdy_a, busy_a, done_a, err_a;
  logic [1:0]  pipe_a = 2'b00;

  assign eaddr_a = ta(int'(idx_a));
  assign edata_a = td(int'(idx_a));
  assign rev_a   = auto_a ? pipe_a[1] : man_rev_a;

  bp_me_cfg_seq_loader #(.addr_width_p(40), .data_width_p(64),
                         .num_entries_p(4), .credits_p(3)) u_a (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_a),
    .entry_idx_o(idx_a), .entry_addr_i(eaddr_a), .entry_data_i(edata_a),
    .fwd_v_o(fwd_v_a), .fwd_ready_and_i(ready_a),
    .fwd_addr_o(faddr_a), .fwd_data_o(fdata_a),
    .rev_v_i(rev_a), .rev_ready_and_o(rev_rdy_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

  // Monitor A: ack generator (2 cycles after accept), accept log, done count
  int          acc_a = 0, dones_a = 0;
  logic [39:0] log_a [64];
  always @(posedge clk) begin
    pipe_a <= {pipe_a[0], fwd_v_a & ready_a};
    if (fwd_v_a && ready_a) begin
      log_a[acc_a % 64] <= faddr_a;
      acc_a <= acc_a + 1;
    end
    if (done_a) dones_a <= dones_a + 1;
  end

  // ---------------- instance B ----------------
  logic        start_b = 1'b0, rev_b = 1'b0;
  logic [1:0]  idx_b;
  logic [39:0] eaddr_b, faddr_b;
  logic [63:0] edata_b, fdata_b;
  logic        fwd_v_b, rev_rdy_b, busy_b, done_b, err_b;

  assign eaddr_b = ta(int'(idx_b));
  assign edata_b = td(int'(idx_b));

  bp_me_cfg_seq_loader #(.addr_width_p(40), .data_width_p(64),
                         .num_entries_p(4), .credits_p(2)) u_b (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b),
    .entry_idx_o(idx_b), .entry_addr_i(eaddr_b), .entry_data_i(edata_b),
    .fwd_v_o(fwd_v_b), .fwd_ready_and_i(1'b1),
    .fwd_addr_o(faddr_b), .fwd_data_o(fdata_b),
    .rev_v_i(rev_b), .rev_ready_and_o(rev_rdy_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

  int acc_b = 0;
  always @(posedge clk) if (fwd_v_b) acc_b <= acc_b + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_auto_a(input string tag);
    int  base_acc, base_done;
    bit  seen;
    base_acc  = acc_a;
    base_done = dones_a;
    seen      = 1'b0;
    auto_a = 1'b1; ready_a = 1'b1;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    chk({tag, "_latency_v"}, fwd_v_a, 1'b1);
    chk({tag, "_first_idx"}, idx_a, 2'd0);
    chk({tag, "_busy"}, busy_a, 1'b1);
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (done_a) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    repeat (3) cyc();
    chk({tag, "_accepts"}, acc_a - base_acc, 4);
    chk({tag, "_done_pulses"}, dones_a - base_done, 1);
    chk({tag, "_err"}, err_a, 1'b0);
    chk({tag, "_idle_busy"}, busy_a, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_addr%0d", tag, i), log_a[(base_acc + i) % 64], ta(i));
    auto_a = 1'b0; ready_a = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #3;
    chk("rst_fwd_v", fwd_v_a, 1'b0);
    chk("rst_rev_rdy", rev_rdy_a, 1'b0);
    chk("rst_flags", {busy_a, done_a, err_a}, 3'b000);
    chk("rst_idx", idx_a, 2'd0);
    cyc();
    reset_n = 1'b1;
    cyc(); cyc();
    chk("idle_busy", busy_a, 1'b0);
    chk("idle_rev_rdy", rev_rdy_a, 1'b0);

    // Full sequence, ready always 1, ack 2 cycles after each accept
    run_auto_a("seq1");

    // Backpressure: payload and idx hold while ready is low
    start_a = 1'b1; cyc(); start_a = 1'b0;
    chk("bp_v_first", fwd_v_a, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("bp_v_%0d", k), fwd_v_a, 1'b1);
      chk($sformatf("bp_idx_%0d", k), idx_a, 2'd0);
      chk($sformatf("bp_addr_%0d", k), faddr_a, ta(0));
      chk($sformatf("bp_data_%0d", k), fdata_a, td(0));
    end
    ready_a = 1'b1; cyc(); ready_a = 1'b0;
    chk("acc0_cnt", u_a.cnt_q, 1);
    chk("acc0_idx", idx_a, 2'd1);

    // Accept and ack in the same cycle with one outstanding
    ready_a = 1'b1; man_rev_a = 1'b1; cyc();
    chk("same_cyc_cnt", u_a.cnt_q, 1);
    chk("same_cyc_idx", idx_a, 2'd2);

    // Ack with nothing outstanding raises the sticky error
    ready_a = 1'b0; cyc();
    chk("drop_cnt", u_a.cnt_q, 0);
    chk("drop_err", err_a, 1'b0);
    cyc(); man_rev_a = 1'b0;
    chk("stray_err", err_a, 1'b1);
    chk("stray_cnt_sat", u_a.cnt_q, 0);

    ready_a = 1'b1; cyc(); cyc(); ready_a = 1'b0;
    chk("drain_cnt", u_a.cnt_q, 2);
    chk("drain_fwd_v", fwd_v_a, 1'b0);
    chk("drain_rev_rdy", rev_rdy_a, 1'b1);
    chk("drain_idx_nowrap", idx_a, 2'd3);
    man_rev_a = 1'b1; cyc(); cyc(); man_rev_a = 1'b0;
    chk("drain_done_early", done_a, 1'b0);
    cyc();
    chk("done_pulse", done_a, 1'b1);
    chk("done_err_held", err_a, 1'b1);
    cyc();
    chk("done_clear", done_a, 1'b0);
    chk("idle_err_held", err_a, 1'b1);
    man_rev_a = 1'b1; cyc(); man_rev_a = 1'b0;
    chk("idle_ack_ignored", err_a, 1'b1);
    start_a = 1'b1; cyc(); start_a = 1'b0;
    chk("start_clears_err", err_a, 1'b0);

    // Fill to 3 outstanding, then drain state with 3 outstanding
    ready_a = 1'b1; cyc(); cyc(); cyc();
    chk("credit_stop_v", fwd_v_a, 1'b0);
    chk("credit_cnt", u_a.cnt_q, 3);
    man_rev_a = 1'b1; cyc(); man_rev_a = 1'b0;
    chk("credit_return_v", fwd_v_a, 1'b1);
    cyc(); ready_a = 1'b0;
    chk("pre_rst_cnt", u_a.cnt_q, 3);
    chk("pre_rst_busy_fwd", {busy_a, fwd_v_a}, 2'b10);

    // Asynchronous reset mid-drain
    #2 reset_n = 1'b0;
    #1;
    chk("arst_fwd_v", fwd_v_a, 1'b0);
    chk("arst_rev_rdy", rev_rdy_a, 1'b0);
    chk("arst_flags", {busy_a, done_a, err_a}, 3'b000);
    chk("arst_idx", idx_a, 2'd0);
    chk("arst_cnt", u_a.cnt_q, 0);
    cyc();
    reset_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("post_rst_no_replay", {fwd_v_a, busy_a}, 2'b00);
    run_auto_a("seq2");

    // Instance B: two credits, no acks
    start_b = 1'b1; cyc(); start_b = 1'b0;
    begin
      int base_b;
      base_b = acc_b;
      repeat (5) cyc();
      chk("b_accepts_2", acc_b - base_b, 2);
      chk("b_fwd_v_stalled", fwd_v_b, 1'b0);
      rev_b = 1'b1; cyc(); rev_b = 1'b0;
      repeat (4) cyc();
      chk("b_accepts_3", acc_b - base_b, 3);
      chk("b_fwd_v_stalled2", fwd_v_b, 1'b0);
      chk("b_err", err_b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_me_cfg_seq_loader.md
BP_ME_CFG_SEQ_LOADER -- requirements
Module: bp_me_cfg_seq_loader

Interface
REQ-001 Parameter addr_width_p, default 40: physical address width of issued config writes.
REQ-002 Parameter data_width_p, default 64: config write data width; fixed at 8-byte size code.
REQ-003 Parameter num_entries_p, default 16: number of table entries written per sequence, ≥1.
REQ-004 Parameter credits_p, default 4: maximum outstanding writes without a response, ≥1.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  single-cycle pulse that begins a sequence; honoured only in IDLE.
REQ-008 entry_idx_o  output  clog2(num_entries_p)  index of the table entry currently requested.
REQ-009 entry_addr_i  input  addr_width_p  address for entry_idx_o; combinational, same cycle.
REQ-010 entry_data_i  input  data_width_p  data for entry_idx_o; combinational, same cycle.
REQ-011 fwd_v_o / fwd_ready_and_i  output/input  1/1  write-command valid/ready handshake.
REQ-012 fwd_addr_o, fwd_data_o  output  addr_width_p, data_width_p  command payload; opcode is always write, size is always 8 bytes.
REQ-013 rev_v_i / rev_ready_and_o  input/output  1/1  write-acknowledge handshake; acks return in order.
REQ-014 busy_o, done_o, err_o  output  1 each  status flags.

Function
REQ-015 FSM states: RESET, IDLE, SEND, DRAIN, DONE.
REQ-016 After reset release, the FSM moves RESET→IDLE on the first clock edge.
REQ-017 In IDLE, start_i=1 moves to SEND, clears idx, outstanding and err_o, and deasserts done_o.
REQ-018 In SEND, fwd_v_o=1 iff outstanding<credits_p; payload is entry_addr_i/entry_data_i for the current idx.
REQ-019 fwd_v_o, once asserted, holds with a stable payload until fwd_ready_and_i is seen.
REQ-020 A command is accepted when fwd_v_o & fwd_ready_and_i are both high; acceptance increments idx and outstanding.
REQ-021 On accepting idx==num_entries_p-1, the FSM moves SEND→DRAIN; idx does not wrap.
REQ-022 rev_ready_and_o is 1 in SEND and DRAIN, and 0 otherwise.
REQ-023 A response is accepted when rev_v_i & rev_ready_and_o are both high; acceptance decrements outstanding.
REQ-024 Acceptance and a response in the same cycle leave outstanding unchanged.
REQ-025 A response with outstanding==0 (and no same-cycle acceptance) sets err_o; outstanding saturates at 0.
REQ-026 rev_v_i outside SEND/DRAIN is ignored and does not set err_o.
REQ-027 When outstanding==0 in DRAIN, the FSM moves to DONE.
REQ-028 DONE asserts done_o for one cycle, then moves to IDLE; done_o is 0 otherwise.
REQ-029 err_o is sticky until the next accepted start_i or reset.
REQ-030 busy_o=1 in SEND and DRAIN.
REQ-031 start_i in SEND, DRAIN or DONE is ignored.
REQ-032 The outstanding counter width is clog2(credits_p+1), and the counter never exceeds credits_p.
REQ-033 With one command per cycle, throughput is 1 per cycle while credits are available; latency from start_i to the first fwd_v_o is 1 cycle.

Reset
REQ-034 reset_n_i=0 asynchronously forces RESET, with idx=0, outstanding=0 and all outputs 0 (including fwd_v_o and rev_ready_and_o).
REQ-035 Reset mid-sequence abandons all outstanding writes; no replay occurs after release.

Verification
REQ-036 num_entries_p=4, ready always 1, ack 2 cycles after each accept → 4 writes with addrs matching the table, done_o pulse once, err_o=0.
REQ-037 credits_p=2, rev_v_i held 0 → exactly 2 accepts, then fwd_v_o=0; a single ack → exactly one more accept.
REQ-038 fwd_ready_and_i=0 for 5 cycles while fwd_v_o=1 → payload stable throughout, idx unchanged.
REQ-039 Same-cycle accept+ack with outstanding=1 → outstanding stays 1.
REQ-040 rev_v_i pulse in SEND with outstanding=0 → err_o=1, held through DONE, cleared by the next start_i.
REQ-041 reset_n_i low in DRAIN with outstanding=3 → immediate outputs 0; after release: IDLE, start_i restarts at idx 0.
